// File: rtl/fmul_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fmul_share_arbiter_pkg
// Shared constants and types for the two-port floating-point multiplier
// arbiter: operand/rounding widths, the default multiplier latency, the
// requester id enum and the {valid, id} tag carried alongside each operation.
// ---------------------------------------------------------------------------
package fmul_share_arbiter_pkg;

    localparam int FP_W        = 32;
    localparam int RM_W        = 2;
    localparam int LATENCY_DEF = 3;
    // Width of the in-flight counter seen by the requesters (holds 0..3)
    localparam int CNT_W       = 2;

    localparam logic [RM_W-1:0] RM_NEAREST = 2'b00;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    // The requester that should win the next contested cycle
    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/fmul_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// fmul_share_arbiter_if
// Bundles everything between the arbiter and its neighbours except clock and
// reset: the global stall, both requester handshakes, the multiplier
// operand/result bus and the result/occupancy outputs.
//   slave  : the arbiter side (drives ready, fm_*, res_*, inflight, busy)
//   master : the surrounding logic (drives stall, req*, fm_s)
// ---------------------------------------------------------------------------
interface fmul_share_arbiter_if;
    import fmul_share_arbiter_pkg::*;

    logic              stall;

    logic              req0_valid;
    logic [FP_W-1:0]   req0_a;
    logic [FP_W-1:0]   req0_b;
    logic [RM_W-1:0]   req0_rm;
    logic              req0_ready;

    logic              req1_valid;
    logic [FP_W-1:0]   req1_a;
    logic [FP_W-1:0]   req1_b;
    logic [RM_W-1:0]   req1_rm;
    logic              req1_ready;

    logic [FP_W-1:0]   fm_a;
    logic [FP_W-1:0]   fm_b;
    logic [RM_W-1:0]   fm_rm;
    logic              fm_e;
    logic              fm_clrn;
    logic [FP_W-1:0]   fm_s;

    logic [FP_W-1:0]   res_data;
    logic              res0_valid;
    logic              res1_valid;
    logic [CNT_W-1:0]  inflight;
    logic              busy;

    modport slave (
        input  stall,
        input  req0_valid, req0_a, req0_b, req0_rm,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_rm,
        output req1_ready,
        output fm_a, fm_b, fm_rm, fm_e, fm_clrn,
        input  fm_s,
        output res_data, res0_valid, res1_valid, inflight, busy
    );

    modport master (
        output stall,
        output req0_valid, req0_a, req0_b, req0_rm,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_rm,
        input  req1_ready,
        input  fm_a, fm_b, fm_rm, fm_e, fm_clrn,
        output fm_s,
        input  res_data, res0_valid, res1_valid, inflight, busy
    );

endinterface

// File: rtl/fmul_tag_pipe.sv
// ---------------------------------------------------------------------------
// fmul_tag_pipe
// Shift register of {valid, id} tags that runs in lock-step with the
// multiplier stage registers, so the tail entry always describes the
// result currently on fm_s. Also keeps a running count of valid entries.
//   clk, clr   : clock, asynchronous active-high clear
//   en         : advance (same enable as the multiplier stages)
//   issue      : a real operation enters this cycle (0 = bubble)
//   issue_id   : owner of the entering operation
//   tail       : tag aligned with the multiplier output
//   occupancy  : number of valid tags currently held
// ---------------------------------------------------------------------------
module fmul_tag_pipe
    import fmul_share_arbiter_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int OCC_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             issue,
    input  req_id_e          issue_id,
    output tag_t             tail,
    output logic [OCC_W-1:0] occupancy
);

    tag_t stages [LATENCY];

    // Tags shift only when the multiplier advances, so a stall freezes both
    // together. The counter adds the entering op and drops the op leaving
    // from the tail; both at once cancel out.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
            occupancy <= '0;
        end else if (en) begin
            stages[0] <= '{valid: issue, id: issue_id};
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
            if (issue && !tail.valid) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!issue && tail.valid) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    assign tail = stages[LATENCY-1];

endmodule

// File: rtl/fmul_share_arbiter.sv
// ---------------------------------------------------------------------------
// fmul_share_arbiter
// Lets two requesters share one pipelined single-precision multiplier.
// A round-robin arbiter issues at most one operation per cycle; a tag pipe
// remembers who issued each in-flight op and raises that requester's
// result-valid pulse when the product reaches fm_s.
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset; discards in-flight operations
//   bus  : slave side of fmul_share_arbiter_if (stall, requester handshakes,
//          multiplier operand/result bus, res_*, inflight, busy)
// ---------------------------------------------------------------------------
module fmul_share_arbiter
    import fmul_share_arbiter_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int NREQ    = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    fmul_share_arbiter_if.slave  bus
);

    localparam int OCC_W = $clog2(LATENCY + 1);

    logic [NREQ-1:0]  req_valid;
    logic             contested;
    logic             issue;
    req_id_e          grant_id;
    req_id_e          rr_ptr;
    tag_t             tail;
    logic [OCC_W-1:0] occupancy;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign contested = &req_valid;

    // Grant selection: a lone requester always wins; when both ask, the
    // round-robin pointer decides. Nothing issues while stalled or in reset,
    // and in that case a bubble with zeroed operands goes down the pipe.
    always_comb begin
        grant_id = REQ0;
        if (contested) begin
            grant_id = rr_ptr;
        end else if (bus.req1_valid) begin
            grant_id = REQ1;
        end
        issue = (|req_valid) && !bus.stall && !clr;
    end

    assign bus.req0_ready = issue && (grant_id == REQ0);
    assign bus.req1_ready = issue && (grant_id == REQ1);

    assign bus.fm_a  = !issue ? '0 : (grant_id == REQ1) ? bus.req1_a  : bus.req0_a;
    assign bus.fm_b  = !issue ? '0 : (grant_id == REQ1) ? bus.req1_b  : bus.req0_b;
    assign bus.fm_rm = !issue ? RM_NEAREST
                              : (grant_id == REQ1) ? bus.req1_rm : bus.req0_rm;
    assign bus.fm_e    = !bus.stall;
    assign bus.fm_clrn = !clr;

    // The pointer only moves after a contested issue, handing priority to
    // the loser; uncontested traffic does not disturb fairness.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rr_ptr <= REQ0;
        end else if (contested && !bus.stall) begin
            rr_ptr <= other_id(grant_id);
        end
    end

    fmul_tag_pipe #(
        .LATENCY (LATENCY),
        .OCC_W   (OCC_W)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (clr),
        .en        (bus.fm_e),
        .issue     (issue),
        .issue_id  (grant_id),
        .tail      (tail),
        .occupancy (occupancy)
    );

    // A stalled tail is held for the next enabled cycle, so the pulse is
    // suppressed until then to avoid reporting the same result twice.
    assign bus.res_data   = bus.fm_s;
    assign bus.res0_valid = tail.valid && (tail.id == REQ0) && !bus.stall;
    assign bus.res1_valid = tail.valid && (tail.id == REQ1) && !bus.stall;
    assign bus.inflight   = CNT_W'(occupancy);
    assign bus.busy       = (occupancy != '0);

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fmul_share_arbiter
// Drives the arbiter against a stub three-stage multiplier whose result
// table holds hand-computed single-precision products for the operand
// pairs used here. Cycle-by-cycle vectors give inputs and expected outputs;
// the reset-in-flight case is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_fmul_share_arbiter;
    import fmul_share_arbiter_pkg::*;

    localparam logic [31:0] A15  = 32'h3fc00000;
    localparam logic [31:0] P15  = 32'h40100000;
    localparam logic [31:0] FMAX = 32'h7f7fffff;
    localparam logic [31:0] INF  = 32'h7f800000;
    localparam logic [31:0] MINN = 32'h00800000;
    localparam logic [31:0] HALF = 32'h3f000000;
    localparam logic [31:0] PDEN = 32'h00400000;
    localparam logic [31:0] DEN  = 32'h003fffff;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] PD   = 32'h007ffffe;
    localparam logic [31:0] XOP  = 32'h00ffffff;
    localparam logic [31:0] NAN  = 32'h7fc00000;

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [1:0]  rm0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [1:0]  rm1;
        logic        stall;
        logic        rdy0, rdy1, r0, r1;
        logic [31:0] data;
        logic [1:0]  infl;
        logic [31:0] fma;
        logic [1:0]  fmrm;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fmul_share_arbiter_if bus();

    fmul_share_arbiter #(
        .LATENCY (3),
        .NREQ    (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Stub multiplier: three enabled stage registers, cleared by fm_clrn
    function automatic logic [31:0] fmul_stub(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {A15,  A15 }: return P15;
            {FMAX, FMAX}: return INF;
            {MINN, HALF}: return PDEN;
            {DEN,  TWO }: return PD;
            {INF,  XOP }: return INF;
            {INF,  32'h0}: return NAN;
            default:      return 32'h0;
        endcase
    endfunction

    logic [31:0] st1, st2, st3;
    always @(posedge clk or negedge bus.fm_clrn) begin
        if (!bus.fm_clrn) begin
            st1 <= '0; st2 <= '0; st3 <= '0;
        end else if (bus.fm_e) begin
            st1 <= fmul_stub(bus.fm_a, bus.fm_b);
            st2 <= st1;
            st3 <= st2;
        end
    end
    assign bus.fm_s = st3;

    function automatic vec_t mk(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] rm0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] rm1,
        input logic stall, input logic rdy0, input logic rdy1, input logic r0, input logic r1,
        input logic [31:0] data, input logic [1:0] infl, input logic [31:0] fma, input logic [1:0] fmrm);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.rm0 = rm0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rm1 = rm1;
        v.stall = stall; v.rdy0 = rdy0; v.rdy1 = rdy1; v.r0 = r0; v.r1 = r1;
        v.data = data; v.infl = infl; v.fma = fma; v.fmrm = fmrm;
        return v;
    endfunction

    function automatic vec_t idle(input logic r0, input logic r1, input logic [31:0] data, input logic [1:0] infl);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, data, infl, 0, 0);
    endfunction

    function automatic vec_t both(input logic rdy0, input logic rdy1, input logic r0, input logic r1,
                                  input logic [31:0] data, input logic [1:0] infl,
                                  input logic [31:0] fma, input logic [1:0] fmrm);
        return mk(1, FMAX, FMAX, 0, 1, MINN, HALF, 3, 0, rdy0, rdy1, r0, r1, data, infl, fma, fmrm);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.stall      = v.stall;
        bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_rm = v.rm0;
        bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_rm = v.rm1;
    endtask

    task automatic checkVector(input int i);
        vec_t v;
        v = vecs[i];
        checkOutput($sformatf("v%0d.ready0", i),   32'(bus.req0_ready), 32'(v.rdy0));
        checkOutput($sformatf("v%0d.ready1", i),   32'(bus.req1_ready), 32'(v.rdy1));
        checkOutput($sformatf("v%0d.res0", i),     32'(bus.res0_valid), 32'(v.r0));
        checkOutput($sformatf("v%0d.res1", i),     32'(bus.res1_valid), 32'(v.r1));
        checkOutput($sformatf("v%0d.inflight", i), 32'(bus.inflight),   32'(v.infl));
        checkOutput($sformatf("v%0d.busy", i),     32'(bus.busy),       32'(v.infl != 0));
        checkOutput($sformatf("v%0d.fm_a", i),     bus.fm_a,            v.fma);
        checkOutput($sformatf("v%0d.fm_rm", i),    32'(bus.fm_rm),      32'(v.fmrm));
        checkOutput($sformatf("v%0d.fm_e", i),     32'(bus.fm_e),       32'(!v.stall));
        if (v.r0 || v.r1) begin
            checkOutput($sformatf("v%0d.res_data", i), bus.res_data, v.data);
        end
    endtask

    // Vectors are applied just after a rising edge and checked at the
    // following falling edge.
    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Single requester 0: result three cycles after acceptance
        vecs.push_back(mk(1, A15, A15, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, A15, 0));
        vecs.push_back(idle(0, 0, 0, 1));
        vecs.push_back(idle(0, 0, 0, 1));
        vecs.push_back(idle(1, 0, P15, 1));
        vecs.push_back(idle(0, 0, 0, 0));
        // Both requesting every cycle: alternating grants, full pipe
        vecs.push_back(both(1, 0, 0, 0, 0,    0, FMAX, 0));
        vecs.push_back(both(0, 1, 0, 0, 0,    1, MINN, 3));
        vecs.push_back(both(1, 0, 0, 0, 0,    2, FMAX, 0));
        vecs.push_back(both(0, 1, 1, 0, INF,  3, MINN, 3));
        vecs.push_back(both(1, 0, 0, 1, PDEN, 3, FMAX, 0));
        vecs.push_back(both(0, 1, 1, 0, INF,  3, MINN, 3));
        vecs.push_back(idle(0, 1, PDEN, 3));
        vecs.push_back(idle(1, 0, INF,  2));
        vecs.push_back(idle(0, 1, PDEN, 1));
        vecs.push_back(idle(0, 0, 0,    0));
        // Back-to-back requester 0: infinity then NaN on consecutive cycles
        vecs.push_back(mk(1, INF, XOP,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, INF, 0));
        vecs.push_back(mk(1, INF, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, INF, 0));
        vecs.push_back(idle(0, 0, 0,   2));
        vecs.push_back(idle(1, 0, INF, 2));
        vecs.push_back(idle(1, 0, NAN, 1));
        vecs.push_back(idle(0, 0, 0,   0));
        // Idle gaps between issues: bubbles never pulse
        vecs.push_back(mk(1, A15, A15, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, A15, 0));
        vecs.push_back(idle(0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, MINN, HALF, 0, 0, 0, 1, 0, 0, 0, 1, MINN, 0));
        vecs.push_back(idle(1, 0, P15,  2));
        vecs.push_back(idle(0, 0, 0,    1));
        vecs.push_back(idle(0, 1, PDEN, 1));
        vecs.push_back(idle(0, 0, 0,    0));
        // Issue requester 1, then stall four cycles with requester 0 waiting
        vecs.push_back(mk(0, 0, 0, 0, 1, DEN, TWO, 1, 0, 0, 1, 0, 0, 0, 0, DEN, 1));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, A15, A15, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        vecs.push_back(mk(1, A15, A15, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, A15, 2));
        vecs.push_back(idle(0, 0, 0,   2));
        vecs.push_back(idle(0, 1, PD,  2));
        vecs.push_back(idle(1, 0, P15, 1));
        vecs.push_back(idle(0, 0, 0,   0));
        // Contested prefix used by the reset-in-flight sequence
        vecs.push_back(both(1, 0, 0, 0, 0, 0, FMAX, 0));
        vecs.push_back(both(0, 1, 0, 0, 0, 1, MINN, 3));
        vecs.push_back(both(1, 0, 0, 0, 0, 2, FMAX, 0));

        // Reset state, with a requester already asking
        clr = 1'b1;
        applyStimulus(idle(0, 0, 0, 0));
        bus.req0_valid = 1'b1;
        #2;
        checkOutput("rst.ready0",   32'(bus.req0_ready), 32'd0);
        checkOutput("rst.fm_clrn",  32'(bus.fm_clrn),    32'd0);
        checkOutput("rst.inflight", 32'(bus.inflight),   32'd0);
        checkOutput("rst.busy",     32'(bus.busy),       32'd0);
        checkOutput("rst.res0",     32'(bus.res0_valid), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        applyStimulus(idle(0, 0, 0, 0));
        #1;
        checkOutput("rst.fm_clrn_released", 32'(bus.fm_clrn), 32'd1);
        @(posedge clk);
        #1;

        runVectors(0, vecs.size() - 4);

        // Three ops in flight, then an asynchronous reset mid-cycle
        runVectors(vecs.size() - 3, vecs.size() - 1);
        applyStimulus(idle(0, 0, 0, 0));
        #1;
        checkOutput("mid.inflight_before", 32'(bus.inflight), 32'd3);
        #2;
        clr = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checkOutput("mid.inflight", 32'(bus.inflight),   32'd0);
        checkOutput("mid.busy",     32'(bus.busy),       32'd0);
        checkOutput("mid.ready0",   32'(bus.req0_ready), 32'd0);
        checkOutput("mid.ready1",   32'(bus.req1_ready), 32'd0);
        checkOutput("mid.fm_clrn",  32'(bus.fm_clrn),    32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        applyStimulus(idle(0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mid.drain%0d.res0", i), 32'(bus.res0_valid), 32'd0);
            checkOutput($sformatf("mid.drain%0d.res1", i), 32'(bus.res1_valid), 32'd0);
            checkOutput($sformatf("mid.drain%0d.inflight", i), 32'(bus.inflight), 32'd0);
            @(posedge clk);
            #1;
        end
        // First contested grant after reset belongs to requester 0
        applyStimulus(both(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("post.ready0", 32'(bus.req0_ready), 32'd1);
        checkOutput("post.ready1", 32'(bus.req1_ready), 32'd0);
        checkOutput("post.fm_a",   bus.fm_a,            FMAX);
        @(posedge clk);
        #1;
        applyStimulus(idle(0, 0, 0, 0));
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fmul_share_arbiter.md
Name: fmul_share_arbiter

Overview:
- Shares one pipelined single-precision multiplier (pipelined_fmul: a, b, rm, e, s; clear input fm_clrn) between two requesters.
- Round-robin arbitration, one issue per cycle.
- Tracks owner of every in-flight operation in a tag pipeline aligned to the multiplier latency; steers result s back to the issuing requester with a valid pulse.
- Sits between the FP issue logic of two pipeline ports and the fmul datapath.

Parameters:
LATENCY, 3, clock edges from fmul input sample to valid s (fmul stage-register count)
NREQ, 2, requester count (fixed 2; parameter is documentation only)

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous reset, active-high
stall  in  1  global freeze: holds fmul and tag pipeline
req0_valid  in  1  requester 0 has an operation
req0_a  in  32  operand a
req0_b  in  32  operand b
req0_rm  in  2  rounding mode
req0_ready  out  1  requester 0 operation accepted this cycle
req1_valid/req1_a/req1_b/req1_rm/req1_ready  same as requester 0
fm_a  out  32  to fmul a
fm_b  out  32  to fmul b
fm_rm  out  2  to fmul rm
fm_e  out  1  to fmul e (stage enable)
fm_clrn  out  1  to fmul clrn, equals ~clr
fm_s  in  32  fmul result
res_data  out  32  result, equals fm_s
res0_valid  out  1  res_data belongs to requester 0 this cycle
res1_valid  out  1  res_data belongs to requester 1 this cycle
inflight  out  2  valid ops in tag pipeline (0..LATENCY)
busy  out  1  inflight != 0

Behaviour:
- fm_e = ~stall. When stall=1: no grant, both ready=0, tag pipeline and inflight hold, fmul frozen.
- Grant is combinational. Only one valid: grant it. Both valid: grant the requester pointed to by rr_ptr.
- Granted requester's a/b/rm drive fm_*. No grant: fm_a=fm_b=0, fm_rm=0; a bubble (tag valid=0) is issued.
- reqN_ready = grant to N & ~stall. Handshake is valid&ready. Requester holds operands stable while valid=1 and ready=0.
- rr_ptr register: after a contested grant (both valid, not stalled), rr_ptr = ~granted id. Uncontested grants leave rr_ptr unchanged.
- Tag pipeline: LATENCY entries of {valid, id}. Shifts on every cycle with fm_e=1; entry 0 loads {issue, grant_id}.
- Tail entry aligns with fm_s. res0_valid = tail.valid & tail.id==0; res1_valid = tail.valid & tail.id==1. These are single-cycle pulses with no result backpressure; requesters must accept.
- Result for an op accepted at edge k appears on res_data during the cycle after edge k+LATENCY-1, when no stall intervenes. Each stalled cycle extends this by one.
- inflight += issue, -= tail.valid on each enabled edge. Simultaneous issue and retire leaves it unchanged. Never exceeds LATENCY.
- Reset (async, any time including mid-operation): all tags invalid, inflight=0, rr_ptr=0, ready=0 while clr=1, res*_valid=0, fm_clrn=0. In-flight ops are discarded, not replayed.
- After clr deasserts: first contested grant goes to requester 0.

Decomposition:
- Shared package: FP_W=32, RM_W=2, RM_NEAREST=2'b00, tag struct/localparam widths, LATENCY default.
- One sub-module, fmul_tag_pipe: enable-gated {valid,id} shift register with tail output and occupancy count.
- Arbiter/mux logic stays in the top.

Test Plan:
- Req0 only, a=b=32'h3fc00000, rm=0 -> req0_ready=1 at once; LATENCY cycles later res0_valid=1, res_data=32'h40100000, res1_valid=0.
- Both valid every cycle: req0 a=b=32'h7f7fffff; req1 a=32'h00800000, b=32'h3f000000 -> grants alternate 0,1,0,1. Results alternate 32'h7f800000 (res0) and 32'h00400000 (res1); inflight holds at 3.
- Issue req1 (a=32'h003fffff, b=32'h40000000), then stall=1 for 4 cycles -> ready=0, no res pulses, inflight frozen. On release, res1_valid with res_data=32'h007ffffe, delayed by exactly 4 cycles.
- Back-to-back req0 ops 32'h7f800000×32'h00ffffff, then 32'h7f800000×32'h00000000 -> results 32'h7f800000, then NaN with res0_valid on consecutive cycles.
- Three ops in flight, pulse clr mid-stream -> no res*_valid for discarded ops, inflight=0, busy=0. Next contested grant goes to requester 0.
- Idle gaps interleaved with issues -> bubbles produce no valid pulses; inflight tracks exactly.
